// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the multi-set tree pseudo-LRU controller.
package plru_pkg;

    typedef enum logic {
        FLUSH_IDLE  = 1'b0,
        FLUSH_CLEAR = 1'b1
    } flush_state_t;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TOUCH = 2'd1,
        UPD_FILL  = 2'd2,
        UPD_INV   = 2'd3
    } upd_op_t;

    // Heap layout: node n has children 2n+1 / 2n+2, leaves follow the WAYS-1 internal nodes.
    function automatic int left_child(input int node);
        return 2 * node + 1;
    endfunction

    function automatic int right_child(input int node);
        return 2 * node + 2;
    endfunction

    function automatic int parent(input int node);
        return (node - 1) / 2;
    endfunction

    function automatic int leaf_to_way(input int leaf, input int ways);
        return leaf - (ways - 1);
    endfunction

    // Only one update lands per cycle; invalidate beats fill beats touch.
    function automatic upd_op_t upd_select(input logic inv, input logic fill, input logic touch);
        if (inv)
            return UPD_INV;
        else if (fill)
            return UPD_FILL;
        else if (touch)
            return UPD_TOUCH;
        else
            return UPD_NONE;
    endfunction

endpackage

// File: rtl/plru_tree_victim.sv
// Combinational victim chooser for one set: invalid-and-unlocked first, else a lock-aware tree walk.
module plru_tree_victim
    import plru_pkg::*;
#(
    parameter  int WAYS  = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int NODES = WAYS - 1
) (
    input  logic [NODES-1:0] tree,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  lock,
    output logic [WAY_W-1:0] way,
    output logic             all_locked
);

    logic [WAYS-1:0] free;
    logic            found;
    logic            go_right;
    logic            left_lk;
    logic            right_lk;
    int              node;
    int              prefix;
    int              span;

    assign free = ~valid & ~lock;

    // NOTE: every variable gets a default at the top of the block, so no path can leave one
    // holding its old value and infer a latch; blocking '=' is correct in combinational code.
    always_comb begin
        all_locked = &lock;
        way        = '0;
        found      = 1'b0;
        go_right   = 1'b0;
        left_lk    = 1'b0;
        right_lk   = 1'b0;
        node       = 0;
        prefix     = 0;
        span       = 0;

        for (int w = 0; w < WAYS; w++) begin
            if (!found && free[w]) begin
                way   = WAY_W'(w);
                found = 1'b1;
            end
        end

        if (!found && !all_locked) begin
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                // prefix names the current subtree; its children cover ways whose top bits are 2p / 2p+1.
                span     = WAY_W - 1 - lvl;
                left_lk  = 1'b1;
                right_lk = 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if ((w >> span) == 2 * prefix)
                        left_lk = left_lk & lock[w];
                    if ((w >> span) == 2 * prefix + 1)
                        right_lk = right_lk & lock[w];
                end
                go_right = tree[node];
                if (go_right ? right_lk : left_lk)
                    go_right = ~go_right;
                prefix = 2 * prefix + int'(go_right);
                node   = go_right ? right_child(node) : left_child(node);
            end
            way = WAY_W'(leaf_to_way(node, WAYS));
        end
    end

endmodule

// File: rtl/plru_tree_array.sv
// WAYS x SETS tree pseudo-LRU controller with valid tracking, way locks,
// a registered victim response and a one-set-per-cycle flush engine.
module plru_tree_array
    import plru_pkg::*;
#(
    parameter  int WAYS  = 16,
    parameter  int SETS  = 64,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lkp_vld,
    output logic             lkp_rdy,
    input  logic [SET_W-1:0] lkp_set,
    input  logic [WAYS-1:0]  lkp_lock,
    output logic             rsp_vld,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_all_locked,
    input  logic             touch_vld,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             fill_vld,
    input  logic [SET_W-1:0] fill_set,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             inv_vld,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush_req,
    output logic             flush_busy
);

    localparam int               NODES    = WAYS - 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    logic [NODES-1:0] tree_q  [SETS];
    logic [WAYS-1:0]  valid_q [SETS];

    flush_state_t     state_q;
    flush_state_t     state_d;
    logic [SET_W-1:0] flush_cnt_q;

    upd_op_t          upd_op;
    logic [SET_W-1:0] upd_set;
    logic [WAY_W-1:0] upd_way;
    logic [NODES-1:0] upd_tree;
    logic [WAYS-1:0]  upd_valid;
    int               node;

    logic [NODES-1:0] lkp_tree;
    logic [WAYS-1:0]  lkp_valid;
    logic             lkp_fire;
    logic [WAY_W-1:0] vic_way;
    logic             vic_all_locked;

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FLUSH_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == FLUSH_CLEAR) ? flush_cnt_q + SET_W'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FLUSH_IDLE:  if (flush_req) state_d = FLUSH_CLEAR;
            FLUSH_CLEAR: if (flush_cnt_q == LAST_SET) state_d = FLUSH_IDLE;
            default:     state_d = FLUSH_IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (state_q == FLUSH_CLEAR);
        lkp_rdy    = (state_q != FLUSH_CLEAR);
    end

    // Resolve the single winning update and build the set's next tree/valid image.
    always_comb begin
        upd_op  = flush_busy ? UPD_NONE : upd_select(inv_vld, fill_vld, touch_vld);
        upd_set = touch_set;
        upd_way = touch_way;
        case (upd_op)
            UPD_INV: begin
                upd_set = inv_set;
                upd_way = inv_way;
            end
            UPD_FILL: begin
                upd_set = fill_set;
                upd_way = fill_way;
            end
            default: ;
        endcase

        upd_tree  = tree_q[upd_set];
        upd_valid = valid_q[upd_set];
        node      = 0;
        if (upd_op == UPD_FILL || upd_op == UPD_TOUCH) begin
            // Each node on the path points away from the branch just taken.
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                if (upd_way[WAY_W-1-lvl]) begin
                    upd_tree[node] = 1'b0;
                    node           = right_child(node);
                end else begin
                    upd_tree[node] = 1'b1;
                    node           = left_child(node);
                end
            end
        end
        if (upd_op == UPD_FILL)
            upd_valid[upd_way] = 1'b1;
        else if (upd_op == UPD_INV)
            upd_valid[upd_way] = 1'b0;
    end

    // Same-set bypass so a lookup observes this cycle's update.
    always_comb begin
        lkp_tree  = tree_q[lkp_set];
        lkp_valid = valid_q[lkp_set];
        if (upd_op != UPD_NONE && upd_set == lkp_set) begin
            lkp_tree  = upd_tree;
            lkp_valid = upd_valid;
        end
    end

    assign lkp_fire = lkp_vld & lkp_rdy;

    plru_tree_victim #(
        .WAYS (WAYS)
    ) u_victim (
        .tree       (lkp_tree),
        .valid      (lkp_valid),
        .lock       (lkp_lock),
        .way        (vic_way),
        .all_locked (vic_all_locked)
    );

    // NOTE: the state arrays are flops, not RAM, because reset must clear every set in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s]  <= '0;
                valid_q[s] <= '0;
            end
        end else if (flush_busy) begin
            tree_q[flush_cnt_q]  <= '0;
            valid_q[flush_cnt_q] <= '0;
        end else if (upd_op != UPD_NONE) begin
            tree_q[upd_set]  <= upd_tree;
            valid_q[upd_set] <= upd_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld        <= 1'b0;
            rsp_way        <= '0;
            rsp_all_locked <= 1'b0;
        end else begin
            rsp_vld <= lkp_fire;
            if (lkp_fire) begin
                rsp_way        <= vic_way;
                rsp_all_locked <= vic_all_locked;
            end
        end
    end

endmodule
